// File: rtl/dmem_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data-memory responder (slave).
interface dmem_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency single-outstanding data-memory responder with pipeline stall.
// Define DMEM_MISALIGN_ERR_EN to turn misaligned accesses into error responses.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    dmem_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       wdata_q;
    logic              mis_q;
    logic              mis_c;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              capture_c;
    logic              access_c;
    logic              write_en_c;
    logic [31:0]       mem [DEPTH_WORDS];

    logic [ADDR_W-1:0] addr_c;
    logic              unused_addr_bits;
    assign addr_c           = bus.req_addr;
    assign unused_addr_bits = ^{addr_c[ADDR_W-1:IDX_W+2], addr_c[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
    assign mis_c = (addr_c[1:0] != 2'b00);
`else
    assign mis_c = 1'b0;
`endif

    // Next-state: accept in IDLE, count down in BUSY, one response cycle in RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        access_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d   = BUSY;
                    cnt_d     = CNT_W'(LATENCY - 1);
                    capture_c = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    access_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture_c) begin
                we_q    <= bus.req_we;
                idx_q   <= addr_c[IDX_W+1:2];
                wdata_q <= bus.req_wdata;
                mis_q   <= mis_c;
            end
            // Stores leave rdata alone; a misaligned access returns zero.
            if (access_c) begin
                err_q <= mis_q;
                if (mis_q) begin
                    rdata_q <= '0;
                end else if (!we_q) begin
                    rdata_q <= mem[idx_q];
                end
            end else if (state_q == RESP) begin
                err_q <= 1'b0;
            end
        end
    end

    assign write_en_c = access_c & we_q & ~mis_q;

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (write_en_c) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.stall     = ((state_q == IDLE) & bus.req_valid) | (state_q == BUSY);
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 5-stage pipeline: the target end of the MEM-stage load/store interface. Accepts one word read or write request at a time, services it after a fixed, parameterised latency, and returns read data with a one-cycle response strobe. While a request is outstanding it raises a stall to the pipeline. Optionally flags misaligned accesses with an error response.

## Interface
- `ADDR_W`, 32: request address width.
- `DEPTH_WORDS`, 256: number of 32-bit words in the array; power of two, ≥4.
- `LATENCY`, 2: cycles from acceptance to response; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present (MemRead or MemWrite asserted).
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data.
- `req_ready` out 1: responder idle and able to accept.
- `rsp_valid` out 1: one-cycle strobe; response data valid.
- `rsp_rdata` out 32: load data. Holds its value between responses.
- `rsp_err` out 1: misaligned access. Qualified by `rsp_valid`.
- `stall` out 1: freezes the pipeline while a request is pending.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - BUSY: counts down the latency.
  - RESP: drives the response.
- IDLE → BUSY on the edge where `req_valid & req_ready`. On that edge the responder captures `req_we`, `req_addr` and `req_wdata`, and loads the counter with LATENCY−1.
- BUSY decrements the counter each cycle. BUSY → RESP on the edge where the counter equals 0.
- The BUSY → RESP edge performs the array access:
  - Store: writes the captured data.
  - Load: registers the array word into `rsp_rdata`.
- RESP → IDLE unconditionally. The responder accepts no request in RESP.
- Word index = `addr[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so addresses alias modulo DEPTH_WORDS·4.
- Stores do not modify `rsp_rdata`. It keeps the last load value.
- `req_ready` = (state == IDLE).
- `stall` = (IDLE & `req_valid`) | BUSY. It is combinational, so the pipeline stalls in the same cycle the request appears. It is low in RESP so the pipeline advances and captures `rsp_rdata`.
- No response back-pressure: the consumer must take `rsp_valid` when it is asserted.

## Timing
- Request accepted on edge N → `rsp_valid` high for exactly the cycle following edge N+LATENCY.
- Store visibility: a load accepted after the store's RESP cycle returns the new data.
- Throughput: one request per LATENCY+2 cycles.
- A request held during RESP is accepted on the first edge after IDLE is re-entered.
- Reset values:
  - State: IDLE.
  - Counter: 0.
  - `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0.
  - `req_ready` 1.
  - `stall` follows `req_valid`.
- The array is not reset; its contents are undefined until written.
- Reset asserted mid-BUSY abandons the request: no array write occurs and no response is issued.
- `req_valid` dropped after acceptance has no effect; the captured request completes.

## Configuration
- `DMEM_MISALIGN_ERR_EN` defined:
  - `addr[1:0] != 0` on an accepted request still runs the full latency.
  - The store is suppressed.
  - `rsp_rdata` is set to 0 and `rsp_err` is 1 in the RESP cycle.
  - `rsp_err` clears in IDLE.
- Undefined:
  - `addr[1:0]` is ignored.
  - The access proceeds normally.
  - `rsp_err` is tied 0.

## Test plan
- Reset, then LATENCY=2, store 0xDEADBEEF to 0x10 accepted on edge N → `rsp_valid` high only in the cycle after edge N+2. Then load 0x10 → `rsp_rdata`=0xDEADBEEF.
- LATENCY=1 with back-to-back loads of 0x0 and 0x4 held valid → accept edges spaced 3 cycles apart. `stall` is high in every cycle except the RESP cycles.
- DEPTH_WORDS=256: store 0x11111111 to 0x400, then load 0x0 → returns 0x11111111 (aliasing).
- Assert `rst_n`=0 during BUSY of a store of 0xCAFEF00D to 0x20 → no `rsp_valid` is issued. A following load of 0x20 returns the previously written value.
- Load 0x8 returning 0x5A5A5A5A, then store 0xFFFFFFFF to 0xC → `rsp_rdata` stays 0x5A5A5A5A after the store.
- With `DMEM_MISALIGN_ERR_EN`: store to 0x13 → `rsp_err`=1 and `rsp_rdata`=0, and a load of 0x10 shows the word unchanged. Without the macro: `rsp_err` is always 0 and the word at 0x10 is written.
